imm_unit: RTL
=============

# imm_unit

Parametrised, pipelined immediate generator for the RV32I/RV64I core. It extracts and sign- or zero-extends the immediate from a 32-bit instruction word to XLEN bits. The format comes either from the decoder's `imm_ctrl` or from an internal opcode decode. A one-entry valid/ready output register lets it sit between the fetch/decode and execute stages, and it flags and counts instructions whose format is illegal.

## Interface
- `XLEN`, default 32: datapath width; legal values are 32 and 64.
- `AUTO_DECODE`, default 0: 0 takes the format from `imm_ctrl`; 1 derives it from the opcode and `imm_ctrl` is ignored.
- `ERR_CNT_W`, default 8: width of the saturating error counter.
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  `instr` / `imm_ctrl` valid.
- `in_ready`  out  1  the block can accept an input this cycle.
- `instr`  in  32  instruction word.
- `imm_ctrl`  in  3  format select, used when `AUTO_DECODE`=0.
- `out_valid`  out  1  the registered result is valid.
- `out_ready`  in  1  the consumer accepts the result.
- `imm`  out  XLEN  extended immediate.
- `fmt`  out  3  format actually applied.
- `err`  out  1  the instruction had an illegal or reserved format.
- `err_cnt`  out  ERR_CNT_W  count of accepted beats with `err`=1; saturates.

## Operation
- Format codes, each extended to XLEN:
  - 000 I: sext `instr[31:20]`.
  - 001 S: sext {`instr[31:25]`, `instr[11:7]`}.
  - 010 U: sext {`instr[31:12]`, 12'b0}; sign-extends above bit 31 when XLEN=64.
  - 011 B: sext {`instr[31]`, `instr[7]`, `instr[30:25]`, `instr[11:8]`, 0}.
  - 100 J: sext {`instr[31]`, `instr[19:12]`, `instr[20]`, `instr[30:21]`, 0}.
  - 101 Z (CSR zimm): zext `instr[19:15]`.
  - 110 SH (shift amount): zext `instr[25:20]` when XLEN=64; zext `instr[24:20]` when XLEN=32, and `instr[25]`=1 sets `err`.
  - 111 reserved: `imm`=0, `err`=1.
- Auto decode (`AUTO_DECODE`=1), keyed on `instr[6:0]`:
  - 0000011 (load) and 1100111 (JALR) → I.
  - 0010011 (OP-IMM) → SH when funct3 is 001 or 101, else I.
  - 0100011 → S.
  - 0110111 and 0010111 → U.
  - 1100011 → B.
  - 1101111 → J.
  - 1110011 (SYSTEM) → Z when `instr[14]`=1, else I.
  - 0011011 (OP-IMM-32), XLEN=64 only → SH using a 5-bit shamt (`instr[25]`=1 sets `err`) when funct3 is 001 or 101, else I.
  - Any other opcode, or `instr[1:0]`≠11 → `fmt`=111, `imm`=0, `err`=1.
- Handshake:
  - `in_ready` = !`out_valid` || `out_ready`, driven combinationally.
  - An input is accepted when `in_valid` && `in_ready`. On acceptance, `imm`/`fmt`/`err` load the new result and `out_valid` is set.
  - An output is consumed when `out_valid` && `out_ready`. With no acceptance in the same cycle, `out_valid` clears.
  - Consume and accept in the same cycle: `out_valid` stays 1 and the new data appears. Full throughput, no bubble.
  - While `out_valid` && !`out_ready`: `imm`/`fmt`/`err` hold and no input is accepted.
  - `imm`/`fmt`/`err` change only on acceptance. They keep their last value when `out_valid`=0.
- Error counter: `err_cnt` increments on each accepted beat whose result has `err`=1. It holds at all-ones and never wraps.

## Timing
- Latency is one cycle: a result accepted at edge N is valid after edge N.
- Sustained throughput is one instruction per cycle when `out_ready`=1.
- Reset values: `out_valid`=0, `imm`=0, `fmt`=000, `err`=0, `err_cnt`=0. `in_ready`=1 during and after reset.
- Reset mid-operation discards a pending result; no counter update occurs for an input presented during the reset cycle.
- `in_valid` asserted while `in_ready`=0: the input is not taken. The producer must hold it; the block does not latch it.
- The counter reaching saturation on the same beat that has `err`=1 leaves it at all-ones.

## Test plan
1. Reset: `rst`=1 for 2 cycles with `in_valid`=1 → `out_valid`=0, `imm`=0, `err_cnt`=0, `in_ready`=1; nothing is captured.
2. XLEN=32, AUTO=1, `out_ready`=1, back-to-back inputs 0xFFF00093 then 0xFE000EE3 → on consecutive cycles `imm`=0xFFFFFFFF with `fmt`=000, then `imm`=0xFFFFFFFC with `fmt`=011; `out_valid` is continuously 1.
3. Backpressure: `out_ready`=0, present 0x00100093 then 0x00200093 → first result shows `imm`=1, `in_ready`=0, and `imm` holds for 5 cycles; raise `out_ready` → next cycle `imm`=2.
4. Errors: ERR_CNT_W=2, AUTO=1, feed 5 × 0x00000000 → each result has `err`=1, `imm`=0, `fmt`=111; `err_cnt` goes 1, 2, 3, 3, 3.
5. XLEN=64, AUTO=1, inputs 0x80000537, 0x3400D073, 0x02109093 → `imm`=0xFFFFFFFF80000000 (`fmt` 010), then 1 (`fmt` 101), then 33 (`fmt` 110), all with `err`=0.
6. XLEN=32, AUTO=0:
   - `imm_ctrl`=110 with 0x02109093 → `err`=1.
   - `imm_ctrl`=001 with 0xFE112E23 → `imm`=0xFFFFFFFC.
   - `imm_ctrl`=111 → `imm`=0, `err`=1.

Source files
------------

// File: rtl/imm_unit.sv
// imm_unit: immediate generator for an RV32I/RV64I core.
// Extracts the immediate field of a 32-bit instruction and sign- or
// zero-extends it to XLEN bits. The format comes from i_imm_ctrl, or from
// an internal opcode decode when AUTO_DECODE=1. The result sits in a
// one-entry valid/ready output register. Beats with an illegal or reserved
// format raise o_err and bump a saturating counter.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_in_valid/o_in_ready input handshake (o_in_ready is combinational)
//   i_instr               32-bit instruction word
//   i_imm_ctrl            format select, ignored when AUTO_DECODE=1
//   o_out_valid/i_out_ready output handshake
//   o_imm                 extended immediate, XLEN bits
//   o_fmt                 format applied to the held result
//   o_err                 held result had an illegal/reserved format
//   o_err_cnt             saturating count of accepted beats with err=1
module imm_unit #(
  parameter int XLEN        = 32,
  parameter int AUTO_DECODE = 0,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [31:0]          i_instr,
  input  logic [2:0]           i_imm_ctrl,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [XLEN-1:0]      o_imm,
  output logic [2:0]           o_fmt,
  output logic                 o_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  localparam logic [2:0] F_I   = 3'd0;
  localparam logic [2:0] F_S   = 3'd1;
  localparam logic [2:0] F_U   = 3'd2;
  localparam logic [2:0] F_B   = 3'd3;
  localparam logic [2:0] F_J   = 3'd4;
  localparam logic [2:0] F_Z   = 3'd5;
  localparam logic [2:0] F_SH  = 3'd6;
  localparam logic [2:0] F_RSV = 3'd7;

  // Every listed opcode ends in 2'b11, so a compressed/illegal low pair
  // falls through to the reserved format via the default arm.
  function automatic logic [2:0] decode_fmt(input logic [31:0] ins);
    logic is_shift;
    // funct3 001 (SLLI) and 101 (SRLI/SRAI) share bits [13:12] = 01
    is_shift = (ins[13:12] == 2'b01);
    case (ins[6:0])
      7'b0000011, 7'b1100111: decode_fmt = F_I;
      7'b0010011:             decode_fmt = is_shift ? F_SH : F_I;
      7'b0100011:             decode_fmt = F_S;
      7'b0110111, 7'b0010111: decode_fmt = F_U;
      7'b1100011:             decode_fmt = F_B;
      7'b1101111:             decode_fmt = F_J;
      7'b1110011:             decode_fmt = ins[14] ? F_Z : F_I;
      7'b0011011:             decode_fmt = (XLEN == 64) ? (is_shift ? F_SH : F_I) : F_RSV;
      default:                decode_fmt = F_RSV;
    endcase
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] cnt);
    sat_inc = (&cnt) ? cnt : cnt + ERR_CNT_W'(1);
  endfunction

  logic                   w_in_ready;
  logic                   w_accept;
  logic [2:0]             w_fmt;
  logic                   w_sh5;
  logic                   w_err;
  logic signed [XLEN-1:0] w_imm;
  logic signed [11:0]     w_imm_i;
  logic signed [11:0]     w_imm_s;
  logic signed [31:0]     w_imm_u;
  logic signed [12:0]     w_imm_b;
  logic signed [20:0]     w_imm_j;

  logic                   r_vld_p1;
  logic [XLEN-1:0]        r_imm_p1;
  logic [2:0]             r_fmt_p1;
  logic                   r_err_p1;
  logic [ERR_CNT_W-1:0]   r_cnt_p1;

  assign w_fmt = (AUTO_DECODE != 0) ? decode_fmt(i_instr) : i_imm_ctrl;

  // Shift amounts are 5 bits on RV32 and for the RV64 word-sized OP-IMM-32
  // shifts; in both cases a set bit 25 is an illegal shamt.
  assign w_sh5 = (XLEN == 32) ||
                 ((AUTO_DECODE != 0) && (i_instr[6:0] == 7'b0011011));

  assign w_imm_i = i_instr[31:20];
  assign w_imm_s = {i_instr[31:25], i_instr[11:7]};
  assign w_imm_u = {i_instr[31:12], 12'b0};
  assign w_imm_b = {i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_imm_j = {i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

  always_comb begin
    w_imm = '0;
    w_err = 1'b0;
    case (w_fmt)
      F_I:  w_imm = XLEN'(w_imm_i);
      F_S:  w_imm = XLEN'(w_imm_s);
      F_U:  w_imm = XLEN'(w_imm_u);
      F_B:  w_imm = XLEN'(w_imm_b);
      F_J:  w_imm = XLEN'(w_imm_j);
      F_Z:  w_imm = XLEN'(i_instr[19:15]);
      F_SH: begin
        if (w_sh5) begin
          w_imm = XLEN'(i_instr[24:20]);
          w_err = i_instr[25];
        end else begin
          w_imm = XLEN'(i_instr[25:20]);
        end
      end
      default: w_err = 1'b1;
    endcase
  end

  assign w_in_ready = !r_vld_p1 || i_out_ready;
  assign w_accept   = i_in_valid && w_in_ready;

  // Stage p1: output register (one-entry skid-free buffer)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld_p1 <= 1'b0;
      r_imm_p1 <= '0;
      r_fmt_p1 <= F_I;
      r_err_p1 <= 1'b0;
      r_cnt_p1 <= '0;
    end else if (w_accept) begin
      r_vld_p1 <= 1'b1;
      r_imm_p1 <= w_imm;
      r_fmt_p1 <= w_fmt;
      r_err_p1 <= w_err;
      if (w_err) begin
        r_cnt_p1 <= sat_inc(r_cnt_p1);
      end
    end else if (i_out_ready) begin
      r_vld_p1 <= 1'b0;
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = r_vld_p1;
  assign o_imm       = r_imm_p1;
  assign o_fmt       = r_fmt_p1;
  assign o_err       = r_err_p1;
  assign o_err_cnt   = r_cnt_p1;

endmodule
